// File: rtl/multiple_sequencer_if.sv
// multiple_sequencer_if: mask/enable bus between the LM/SM controller and the register-index sequencer; xfer_count exists only with MULTIPLE_SEQ_COUNT_EN
interface multiple_sequencer_if #(
  parameter int NREGS = 8,
  parameter int AW    = 3
);
  logic [NREGS-1:0] imm;
  logic             multiple_enable;
  logic [AW-1:0]    reg_addr;
  logic             flag_multiple;
  logic             pending;
`ifdef MULTIPLE_SEQ_COUNT_EN
  logic [AW:0]      xfer_count;
`endif
  modport master (
    output imm, multiple_enable,
    input  reg_addr, flag_multiple, pending
`ifdef MULTIPLE_SEQ_COUNT_EN
    , input xfer_count
`endif
  );
  modport slave (
    input  imm, multiple_enable,
    output reg_addr, flag_multiple, pending
`ifdef MULTIPLE_SEQ_COUNT_EN
    , output xfer_count
`endif
  );
endinterface

// File: rtl/multiple_sequencer.sv
// multiple_sequencer: LM/SM register-index sequencer, lowest pending register first; MULTIPLE_SEQ_COUNT_EN adds a saturating transfer counter
module multiple_sequencer #(
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input logic clk,
  input logic reset,
  multiple_sequencer_if.slave bus
);
  logic [NREGS-1:0] mask_q, mask_d, mask_rest;
  logic [AW-1:0]    addr;
  assign mask_rest         = mask_q & (mask_q - NREGS'(1));
  assign bus.reg_addr      = addr;
  assign bus.pending       = |mask_q;
  assign bus.flag_multiple = mask_rest == '0;
  // priority encoder: index of the lowest set mask bit, 0 when empty
  always_comb begin
    addr = '0;
    for (int i = NREGS - 1; i >= 0; i--) if (mask_q[i]) addr = AW'(i);
  end
  // track imm while idle, otherwise retire the lowest pending register (empty stays empty)
  always_comb mask_d = bus.multiple_enable ? mask_rest : bus.imm;
  // mask register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mask_q <= '0;
    else mask_q <= mask_d;
  end
`ifdef MULTIPLE_SEQ_COUNT_EN
  logic [AW:0] cnt_q, cnt_d;
  assign bus.xfer_count = cnt_q;
  // count enabled transfers, cleared while idle, saturating at NREGS
  always_comb cnt_d = !bus.multiple_enable ? '0
                    : (|mask_q && cnt_q != (AW+1)'(NREGS)) ? cnt_q + (AW+1)'(1) : cnt_q;
  // transfer counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`endif
endmodule

// File: tb/tb_multiple_sequencer.sv
// tb_multiple_sequencer: table-driven directed check of the LM/SM register-index sequencer
module tb_multiple_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  multiple_sequencer_if #(.NREGS(8), .AW(3)) bus ();
  multiple_sequencer #(.NREGS(8), .AW(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] imm;
    logic       en;
    logic [2:0] addr;
    logic       flag;
    logic       pend;
    logic [3:0] cnt;
  } vec_t;
  vec_t tbl [25];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic chk_out(input string tag, input int a, input int f, input int p, input int c);
    chk({tag, " reg_addr"}, int'(bus.reg_addr), a);
    chk({tag, " flag_multiple"}, int'(bus.flag_multiple), f);
    chk({tag, " pending"}, int'(bus.pending), p);
`ifdef MULTIPLE_SEQ_COUNT_EN
    chk({tag, " xfer_count"}, int'(bus.xfer_count), c);
`else
    if (c < 0) $display("unused count %0d", c);
`endif
  endtask
  task automatic drive(input logic [7:0] imm, input logic en);
    @(negedge clk);
    bus.imm = imm;
    bus.multiple_enable = en;
    #1;
  endtask
  initial begin
    tbl[0]  = '{8'h3C, 1'b0, 3'd0, 1'b1, 1'b0, 4'd0};
    tbl[1]  = '{8'hA6, 1'b0, 3'd2, 1'b0, 1'b1, 4'd0};
    tbl[2]  = '{8'hA6, 1'b1, 3'd1, 1'b0, 1'b1, 4'd0};
    tbl[3]  = '{8'hA6, 1'b1, 3'd2, 1'b0, 1'b1, 4'd1};
    tbl[4]  = '{8'hA6, 1'b1, 3'd5, 1'b0, 1'b1, 4'd2};
    tbl[5]  = '{8'hA6, 1'b1, 3'd7, 1'b1, 1'b1, 4'd3};
    tbl[6]  = '{8'hA6, 1'b1, 3'd0, 1'b1, 1'b0, 4'd4};
    tbl[7]  = '{8'h80, 1'b0, 3'd0, 1'b1, 1'b0, 4'd4};
    tbl[8]  = '{8'h80, 1'b1, 3'd7, 1'b1, 1'b1, 4'd0};
    tbl[9]  = '{8'h80, 1'b1, 3'd0, 1'b1, 1'b0, 4'd1};
    tbl[10] = '{8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 4'd1};
    tbl[11] = '{8'h00, 1'b1, 3'd0, 1'b1, 1'b0, 4'd0};
    tbl[12] = '{8'h00, 1'b1, 3'd0, 1'b1, 1'b0, 4'd0};
    tbl[13] = '{8'h00, 1'b1, 3'd0, 1'b1, 1'b0, 4'd0};
    tbl[14] = '{8'hFF, 1'b0, 3'd0, 1'b1, 1'b0, 4'd0};
    tbl[15] = '{8'hFF, 1'b1, 3'd0, 1'b0, 1'b1, 4'd0};
    tbl[16] = '{8'hFF, 1'b1, 3'd1, 1'b0, 1'b1, 4'd1};
    tbl[17] = '{8'hFF, 1'b1, 3'd2, 1'b0, 1'b1, 4'd2};
    tbl[18] = '{8'h11, 1'b0, 3'd3, 1'b0, 1'b1, 4'd3};
    tbl[19] = '{8'h11, 1'b1, 3'd0, 1'b0, 1'b1, 4'd0};
    tbl[20] = '{8'h11, 1'b1, 3'd4, 1'b1, 1'b1, 4'd1};
    tbl[21] = '{8'h11, 1'b1, 3'd0, 1'b1, 1'b0, 4'd2};
    tbl[22] = '{8'h01, 1'b0, 3'd0, 1'b1, 1'b0, 4'd2};
    tbl[23] = '{8'h01, 1'b1, 3'd0, 1'b1, 1'b1, 4'd0};
    tbl[24] = '{8'h01, 1'b1, 3'd0, 1'b1, 1'b0, 4'd1};
    bus.imm = 8'hFF;
    bus.multiple_enable = 1'b0;
    #2;
    chk_out("in reset", 0, 1, 0, 0);
    drive(8'hFF, 1'b0);
    reset = 1'b0;
    drive(8'hFF, 1'b1);
    chk_out("rst seq step0", 0, 0, 1, 0);
    drive(8'hFF, 1'b1);
    chk_out("rst seq step1", 1, 0, 1, 1);
    drive(8'hFF, 1'b1);
    chk_out("rst seq step2", 2, 0, 1, 2);
    drive(8'hFF, 1'b1);
    chk_out("rst seq mid", 3, 0, 1, 3);
    #1 reset = 1'b1;
    #1;
    chk_out("async reset", 0, 1, 0, 0);
    drive(8'hFF, 1'b1);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(8'hFF, 1'b1);
      chk_out($sformatf("post reset %0d", k), 0, 1, 0, 0);
    end
    for (int k = 0; k < 25; k++) begin
      drive(tbl[k].imm, tbl[k].en);
      chk_out($sformatf("vec %0d", k), int'(tbl[k].addr), int'(tbl[k].flag), int'(tbl[k].pend), int'(tbl[k].cnt));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multiple_sequencer.md
Name: multiple_sequencer

Overview:
Register-index sequencer for the load-multiple (LM) and store-multiple (SM) instructions. It sits beside the control FSM in the multicycle datapath:
- consumes the 8-bit immediate from the instruction register and the controller's multiple-enable strobe;
- produces the register-file address for each transfer (the priority-encoder output) and the flag_multiple completion flag, which steers the controller out of its LM/SM loop states.

Parameters:
- NREGS, 8, number of mask bits / registers; must be a power of two.
- AW, 3, register address width; AW = log2(NREGS).

Ports:
- clk  input  1  system clock; rising edge.
- reset  input  1  asynchronous, active-high reset.
- imm  input  NREGS  LM/SM register mask; wired imm[k] = IR[15-k], so imm[k]=1 selects Rk.
- multiple_enable  input  1  from controller; 0 = load/track mask, 1 = advance one transfer per cycle.
- reg_addr  output  AW  index of the lowest-numbered pending register; feeds the RF write/read address mux.
- flag_multiple  output  1  1 when at most one register is still pending (current transfer is the last, or none).
- pending  output  1  1 when at least one mask bit is still pending.

Behaviour:
- State: mask_q[NREGS-1:0].
- Reset (asynchronous assert, synchronous release on clk): mask_q=0.
  - Outputs during reset: reg_addr=0, flag_multiple=1, pending=0.
- multiple_enable=0: mask_q <= imm every cycle.
  - The mask tracks IR during fetch/decode and the LM/SM setup state (state 2 and the SM setup state both drive enable low).
- multiple_enable=1 and mask_q!=0: mask_q <= mask_q with its lowest set bit cleared.
- multiple_enable=1 and mask_q==0: mask_q holds 0.
- Outputs are combinational from mask_q only (zero-latency, no imm-to-output path):
  - reg_addr = index of the lowest set bit of mask_q; 0 when mask_q==0.
  - pending = |mask_q.
  - flag_multiple = ((mask_q & (mask_q-1)) == 0).
- Order: ascending register number, so the lowest register pairs with the lowest memory address.
- Transfer count: exactly popcount(imm) cycles with enable=1 reach pending=0. Each enabled cycle exposes one address; the controller writes/reads on that same cycle.
- Controller interplay:
  - Single-bit mask: flag_multiple=1 on the first enabled cycle, so the controller does one transfer and exits.
  - Empty mask: flag_multiple=1 and pending=0; the controller gates RF_en and mem_en by |imm.
- Enable dropped mid-sequence (new instruction): the mask reloads from imm on the next edge; the remaining bits are discarded.
- Reset mid-sequence: mask_q clears immediately (asynchronous); no further addresses are produced.
- Arithmetic: mask_q-1 is computed at NREGS width. Wrap on mask_q==0 is irrelevant because that case is covered by the ==0 test.
- No state machine beyond the mask register; "busy" is pending.

Optional Feature:
- Macro: MULTIPLE_SEQ_COUNT_EN.
- Defined:
  - Adds output xfer_count, width AW+1, registered.
  - Cleared to 0 on reset and whenever multiple_enable=0.
  - Incremented on each enabled cycle with mask_q!=0.
  - Saturates at NREGS.
  - Used as the memory-address offset for debug and assertion checks.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset mid-operation: load imm=8'hFF, enable 3 cycles, then pulse reset → reg_addr=0, pending=0, flag_multiple=1 immediately, without waiting for clk; after release with enable=1, nothing is produced.
- Multi-bit mask: imm=8'b1010_0110, enable 0 for one cycle then 1 → reg_addr sequence 1,2,5,7.
  - flag_multiple 0,0,0,1; pending drops on the 5th enabled cycle.
  - With count option: xfer_count 1,2,3,4.
- Single-bit mask: imm=8'h80, enable 1 → first enabled cycle reg_addr=7, flag_multiple=1; next cycle pending=0.
- Empty mask: imm=8'h00, enable 1 for 3 cycles → reg_addr=0, flag_multiple=1, pending=0 throughout; mask_q stays 0.
- Enable drop: imm=8'hFF, enable 1 for 3 cycles (addr 0,1,2), then enable 0 with imm=8'h11, then 1 → sequence restarts 0,4, with flag_multiple=1 at addr 4.
